ucsbece154b_victim_cache_wb: RTL



---
 rtl/ucsbece154b_victim_cache_wb_if.sv | 34 +++
 rtl/ucsbece154b_victim_cache_wb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_victim_cache_wb_if.sv
// Lookup, fill and writeback bus between the L1 data cache, the victim cache
// and the next memory level. The cache takes the slave modport.
interface ucsbece154b_victim_cache_wb_if #(
  parameter int ADDR_WIDTH = 56,
  parameter int LINE_WIDTH = 128
);
  // lookup / take
  logic [ADDR_WIDTH-1:0] raddr_i;
  logic                  take_i;
  logic                  hit_o;
  logic [LINE_WIDTH-1:0] rdata_o;
  logic                  rdirty_o;
  // fill
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] waddr_i;
  logic [LINE_WIDTH-1:0] wdata_i;
  logic                  wdirty_i;
  logic                  wready_o;
  // writeback to memory
  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [ADDR_WIDTH-1:0] wb_addr_o;
  logic [LINE_WIDTH-1:0] wb_data_o;

  modport slave (
    input  raddr_i, take_i, we_i, waddr_i, wdata_i, wdirty_i, wb_ready_i,
    output hit_o, rdata_o, rdirty_o, wready_o, wb_valid_o, wb_addr_o, wb_data_o
  );

  modport master (
    output raddr_i, take_i, we_i, waddr_i, wdata_i, wdirty_i, wb_ready_i,
    input  hit_o, rdata_o, rdirty_o, wready_o, wb_valid_o, wb_addr_o, wb_data_o
  );
endinterface

// File: rtl/ucsbece154b_victim_cache_wb.sv
// Fully-associative write-back victim cache. Holds lines evicted from L1,
// hands them back exclusively on an L1 miss (take), and drains dirty lines
// through a one-entry writeback buffer on replacement or on flush.
module ucsbece154b_victim_cache_wb #(
  parameter int ADDR_WIDTH  = 56,
  parameter int LINE_WIDTH  = 128,
  parameter int NR_ENTRIES  = 4,
  parameter int REPLACEMENT = 0   // 0 = LRU, 1 = FIFO
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic flush_i,
  output logic busy_o,
  ucsbece154b_victim_cache_wb_if.slave bus
);

  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
  localparam int TAG_SIZE     = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int IDX_W        = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [NR_ENTRIES-1:0][IDX_W-1:0] rank_arr_t;
  typedef enum logic {IDLE, FLUSH} state_e;

  localparam idx_t LAST = idx_t'(NR_ENTRIES - 1);

  // entry storage
  logic [NR_ENTRIES-1:0]                valid_q, dirty_q;
  logic [NR_ENTRIES-1:0][TAG_SIZE-1:0]   tag_q;
  logic [NR_ENTRIES-1:0][LINE_WIDTH-1:0] data_q;
  rank_arr_t                             rank_q;

  // control
  state_e state_q;
  idx_t   scan_q;
  logic   busy_q;

  // writeback buffer
  logic                  wb_valid_q;
  logic [TAG_SIZE-1:0]   wb_tag_q;
  logic [LINE_WIDTH-1:0] wb_data_q;

  // Move entry `who` to rank `to`, shifting the ranks in between by one so
  // the ranks stay a permutation. to=0 is a bump, to=LAST is a demotion.
  function automatic rank_arr_t move_rank(input rank_arr_t r, input idx_t who, input idx_t to);
    rank_arr_t o;
    idx_t      old;
    o   = r;
    old = r[who];
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (to < old && r[i] >= to && r[i] < old)
        o[i] = r[i] + idx_t'(1);
      else if (to > old && r[i] > old && r[i] <= to)
        o[i] = r[i] - idx_t'(1);
    end
    o[who] = to;
    return o;
  endfunction

  logic [TAG_SIZE-1:0] tag_r, tag_w;
  assign tag_r = TAG_SIZE'(bus.raddr_i >> OFFSET_WIDTH);
  assign tag_w = TAG_SIZE'(bus.waddr_i >> OFFSET_WIDTH);

  logic rmatch, wmatch;
  idx_t hit_idx, wmatch_idx;

  // Tag compare for the lookup port and the fill port against current contents.
  always_comb begin
    rmatch     = 1'b0;
    hit_idx    = '0;
    wmatch     = 1'b0;
    wmatch_idx = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == tag_r) begin
        rmatch  = 1'b1;
        hit_idx = idx_t'(i);
      end
      if (valid_q[i] && tag_q[i] == tag_w) begin
        wmatch     = 1'b1;
        wmatch_idx = idx_t'(i);
      end
    end
  end

  logic hit, take, idle;
  assign idle = (state_q == IDLE);
  assign hit  = en_i && idle && rmatch;
  assign take = hit && bus.take_i;

  logic [NR_ENTRIES-1:0]                valid_t, dirty_t, valid_n, dirty_n;
  logic [NR_ENTRIES-1:0][TAG_SIZE-1:0]   tag_n;
  logic [NR_ENTRIES-1:0][LINE_WIDTH-1:0] data_n;
  rank_arr_t                             rank_t, rank_n;
  idx_t victim, fill_idx;
  logic has_inv, victim_dirty, wready, fill, evict_wb;
  logic scan_dirty, scan_step, flush_wb;

  // Next-state of the entry array: take first, then fill, or one flush scan step.
  always_comb begin
    // take / hit effects
    valid_t = valid_q;
    dirty_t = dirty_q;
    rank_t  = rank_q;
    if (take) begin
      valid_t[hit_idx] = 1'b0;
      dirty_t[hit_idx] = 1'b0;
      rank_t           = move_rank(rank_q, hit_idx, LAST);
    end else if (hit && REPLACEMENT == 0) begin
      rank_t = move_rank(rank_q, hit_idx, '0);
    end

    // victim: lowest-index free slot, else the oldest rank
    has_inv = 1'b0;
    victim  = '0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_t[i]) begin
        has_inv = 1'b1;
        victim  = idx_t'(i);
      end
    end
    if (!has_inv) begin
      for (int i = 0; i < NR_ENTRIES; i++)
        if (rank_t[i] == LAST) victim = idx_t'(i);
    end
    victim_dirty = valid_t[victim] && dirty_t[victim];

    // a dirty victim needs the buffer empty at this edge; no bypass via wb_ready_i
    wready   = en_i && idle && !(wb_valid_q && victim_dirty);
    fill     = bus.we_i && wready;
    fill_idx = wmatch ? wmatch_idx : victim;
    evict_wb = fill && !wmatch && victim_dirty;

    // flush scan
    scan_dirty = valid_q[scan_q] && dirty_q[scan_q];
    scan_step  = en_i && (state_q == FLUSH) &&
                 (!scan_dirty || !wb_valid_q || bus.wb_ready_i);
    flush_wb   = scan_step && scan_dirty;

    valid_n = valid_t;
    dirty_n = dirty_t;
    tag_n   = tag_q;
    data_n  = data_q;
    rank_n  = rank_t;
    if (fill) begin
      // a taken same-tag entry already has dirty_t cleared, so dirty = wdirty_i
      valid_n[fill_idx] = 1'b1;
      dirty_n[fill_idx] = (wmatch && dirty_t[fill_idx]) || bus.wdirty_i;
      tag_n[fill_idx]   = tag_w;
      data_n[fill_idx]  = bus.wdata_i;
      rank_n            = move_rank(rank_t, fill_idx, '0);
    end
    if (scan_step) begin
      valid_n[scan_q] = 1'b0;
      dirty_n[scan_q] = 1'b0;
      if (scan_q == LAST)
        for (int i = 0; i < NR_ENTRIES; i++) rank_n[i] = idx_t'(i);
    end
  end

  // Entry array registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) rank_q[i] <= idx_t'(i);
    end else begin
      valid_q <= valid_n;
      dirty_q <= dirty_n;
      tag_q   <= tag_n;
      data_q  <= data_n;
      rank_q  <= rank_n;
    end
  end

  // Control FSM: IDLE serves lookups/fills, FLUSH walks every entry once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      scan_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_i && en_i) begin
            state_q <= FLUSH;
            scan_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        FLUSH: begin
          if (scan_step) begin
            if (scan_q == LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              scan_q <= scan_q + idx_t'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Writeback buffer: load on dirty eviction or flush, drain on handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
    end else if (evict_wb) begin
      wb_valid_q <= 1'b1;
      wb_tag_q   <= tag_q[victim];
      wb_data_q  <= data_q[victim];
    end else if (flush_wb) begin
      wb_valid_q <= 1'b1;
      wb_tag_q   <= tag_q[scan_q];
      wb_data_q  <= data_q[scan_q];
    end else if (wb_valid_q && bus.wb_ready_i) begin
      wb_valid_q <= 1'b0;
    end
  end

  assign busy_o         = busy_q;
  assign bus.hit_o      = hit;
  assign bus.rdata_o    = hit ? data_q[hit_idx] : '0;
  assign bus.rdirty_o   = hit && dirty_q[hit_idx];
  assign bus.wready_o   = wready;
  assign bus.wb_valid_o = wb_valid_q;
  assign bus.wb_addr_o  = ADDR_WIDTH'(wb_tag_q) << OFFSET_WIDTH;
  assign bus.wb_data_o  = wb_data_q;

endmodule
